// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns the architectural HI/LO registers and holds
// Busy for a fixed latency while a mult/multu/div/divu result is pending.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    mdu_op_e       op_q,  op_d;
    logic [31:0]   a_q,   a_d;
    logic [31:0]   b_q,   b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q,  hi_d;
    logic [31:0]   lo_q,  lo_d;

    // Result datapath works on the latched operands; the counter only decides
    // when it gets committed.
    logic        is_signed;
    logic [63:0] ext_a, ext_b, prod;
    logic        a_neg, b_neg, div_zero;
    logic [31:0] abs_a, abs_b, dvd, dvs, q_mag, r_mag, quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        res_we;

    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign ext_a     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign ext_b     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod      = ext_a * ext_b;

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_neg    = is_signed && a_q[31];
    assign b_neg    = is_signed && b_q[31];
    assign abs_a    = a_neg ? (~a_q + 32'd1) : a_q;
    assign abs_b    = b_neg ? (~b_q + 32'd1) : b_q;
    assign div_zero = (b_q == 32'd0);
    assign dvd      = abs_a;
    assign dvs      = div_zero ? 32'd1 : abs_b;
    assign q_mag    = dvd / dvs;
    assign r_mag    = dvd % dvs;
    assign quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        res_we = 1'b0;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quot;
                res_we = !div_zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (cnt_q != '0) begin
            // In flight: new Start requests are ignored until the count drains.
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE && res_we) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end else if (Start) begin
            case (mdu_op_e'(MDUOp))
                OP_MULT, OP_MULTU: begin
                    op_d  = mdu_op_e'(MDUOp);
                    a_d   = A;
                    b_d   = B;
                    cnt_d = MULT_LOAD;
                end
                OP_DIV, OP_DIVU: begin
                    op_d  = mdu_op_e'(MDUOp);
                    a_d   = A;
                    b_d   = B;
                    cnt_d = DIV_LOAD;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign Busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
